// File: rtl/bus_if.sv
// Valid/ready request bus shared by the register-driving master and its responders.
interface bus_if;
    logic        valid;
    logic        read;
    logic        write;
    logic [15:0] addr;
    logic [31:0] write_data;
    logic        ready;
    logic [31:0] read_data;

    modport master (
        output valid, read, write, addr, write_data,
        input  ready, read_data
    );

    modport slave (
        input  valid, read, write, addr, write_data,
        output ready, read_data
    );
endinterface

// File: rtl/slave_reg.sv
// Bus responder serving one request at a time from a local register file,
// completing after WAIT_CYCLES wait states with a registered ready pulse.
module slave_reg #(
    parameter int unsigned NUM_REGS    = 16,
    parameter logic [15:0] BASE_ADDR   = 16'h0010,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  reset,
    bus_if.slave  busa,
    output logic  err
);
    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [15:0] SPAN     = 16'(4 * NUM_REGS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic [31:0] read_data_q, read_data_d;
    logic        err_q, err_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    logic             req_rd, req_wr, hit;
    logic [15:0]      req_addr, off;
    logic [IDX_W-1:0] idx;

    // With zero wait states the response is produced on the capture edge,
    // so decode must look through to the live bus while idle.
    always_comb begin
        req_rd   = (state_q == ST_IDLE) ? busa.read  : rd_q;
        req_wr   = (state_q == ST_IDLE) ? busa.write : wr_q;
        req_addr = (state_q == ST_IDLE) ? busa.addr  : addr_q;
        off      = req_addr - BASE_ADDR;
        hit      = (req_addr >= BASE_ADDR) && (off < SPAN) && (off[1:0] == 2'b00);
        idx      = off[IDX_W+1:2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            read_data_q <= '0;
            err_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (busa.valid) begin
                    rd_d    = busa.read;
                    wr_d    = busa.write;
                    addr_d  = busa.addr;
                    wdata_d = busa.write_data;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_d     = (state_d == ST_RESP);
        read_data_d = '0;
        err_d       = 1'b0;
        if (state_d == ST_RESP) begin
            if (req_rd && !req_wr && hit) read_data_d = regs_q[idx];
            err_d = (req_rd || req_wr) && !((req_rd ^ req_wr) && hit);
        end
        regs_d = regs_q;
        if (state_q == ST_RESP && wr_q && !rd_q && hit) regs_d[idx] = wdata_q;
    end

    assign busa.ready     = ready_q;
    assign busa.read_data = read_data_q;
    assign err            = err_q;
endmodule

// File: tb/tb_slave_reg.sv
// Drives three slave_reg instances (0, 1 and 3 wait states) with identical
// stimulus and checks every cycle against a register-file reference model.
module tb_slave_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [15:0] ad = '0;
    logic [31:0] wd = '0;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    bus_if b0 ();
    bus_if b1 ();
    bus_if b3 ();

    assign b0.valid = v;  assign b0.read = rd;  assign b0.write = wr;  assign b0.addr = ad;  assign b0.write_data = wd;
    assign b1.valid = v;  assign b1.read = rd;  assign b1.write = wr;  assign b1.addr = ad;  assign b1.write_data = wd;
    assign b3.valid = v;  assign b3.read = rd;  assign b3.write = wr;  assign b3.addr = ad;  assign b3.write_data = wd;

    logic [2:0]  rdy, errv;
    logic [31:0] rdat [3];

    slave_reg #(.NUM_REGS(16), .BASE_ADDR(16'h0010), .WAIT_CYCLES(0), .RESET_VAL(32'h0))
        dut0 (.clk(clk), .reset(rst_n), .busa(b0.slave), .err(errv[0]));
    slave_reg #(.NUM_REGS(16), .BASE_ADDR(16'h0010), .WAIT_CYCLES(1), .RESET_VAL(32'h0))
        dut1 (.clk(clk), .reset(rst_n), .busa(b1.slave), .err(errv[1]));
    slave_reg #(.NUM_REGS(16), .BASE_ADDR(16'h0010), .WAIT_CYCLES(3), .RESET_VAL(32'h0))
        dut3 (.clk(clk), .reset(rst_n), .busa(b3.slave), .err(errv[2]));

    assign rdy[0] = b0.ready;  assign rdat[0] = b0.read_data;
    assign rdy[1] = b1.ready;  assign rdat[1] = b1.read_data;
    assign rdy[2] = b3.ready;  assign rdat[2] = b3.read_data;

    function automatic int wc(input int j);
        return (j == 0) ? 0 : (j == 1) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference behaviour: 16 words at 0x10..0x4C, word-aligned only.
    task automatic model_step(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d,
                              output logic [31:0] xrd, output logic xerr);
        int  ai;
        bit  h;
        ai   = int'(a);
        h    = (ai >= 16) && (ai < 16 + 64) && (ai % 4 == 0);
        xrd  = '0;
        xerr = 1'b0;
        if (r && !w && h)      xrd = mem[(ai - 16) / 4];
        else if (w && !r && h) mem[(ai - 16) / 4] = d;
        else if (r || w)       xerr = 1'b1;
    endtask

    task automatic txn(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [31:0] xrd, input logic xerr, input string nm);
        @(negedge clk);
        rd = r; wr = w; ad = a; wd = d; v = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0) begin v = 1'b0; rd = 1'b0; wr = 1'b0; ad = $urandom; wd = $urandom; end
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("%s dut%0d ready k=%0d", nm, j, k), {31'b0, rdy[j]}, {31'b0, k == wc(j)});
                chk($sformatf("%s dut%0d rdata k=%0d", nm, j, k), rdat[j], (k == wc(j)) ? xrd : 32'h0);
                chk($sformatf("%s dut%0d err k=%0d", nm, j, k), {31'b0, errv[j]}, {31'b0, (k == wc(j)) && xerr});
            end
        end
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] xrd;
        logic        xerr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] xr;
        logic        xe;
        logic [15:0] ra;

        tbl[0]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'h0,        1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'h0050, 32'h12345678, 32'h0,        1'b1};
        tbl[4]  = '{1'b0, 1'b1, 16'h0012, 32'h87654321, 32'h0,        1'b1};
        tbl[5]  = '{1'b1, 1'b0, 16'h0014, 32'h0,        32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'h0010, 32'h11111111, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 16'h0010, 32'h22222222, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 1'b1, 16'h004C, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'h004C, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 16'h000C, 32'h0,        32'h0,        1'b1};
        tbl[12] = '{1'b1, 1'b0, 16'h0050, 32'h0,        32'h0,        1'b1};

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        // Reset held with a request pending: nothing may respond.
        v = 1'b1; rd = 1'b0; wr = 1'b1; ad = 16'h0010; wd = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("reset dut%0d ready", j), {31'b0, rdy[j]}, 32'h0);
                chk($sformatf("reset dut%0d rdata", j), rdat[j], 32'h0);
                chk($sformatf("reset dut%0d err", j), {31'b0, errv[j]}, 32'h0);
            end
        end
        v = 1'b0; wr = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            model_step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, xr, xe);
            txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].xrd, tbl[i].xerr, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            ra = 16'h0010 + 16'(4 * i);
            txn(1'b1, 1'b0, ra, 32'h0, mem[i], 1'b0, $sformatf("sweep r%0d", i));
        end

        // Held valid: acceptance every WAIT_CYCLES+2 edges while valid stays high.
        model_step(1'b1, 1'b0, 16'h0010, 32'h0, xr, xe);
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; ad = 16'h0010; v = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 8) begin v = 1'b0; rd = 1'b0; end
            for (int j = 0; j < 3; j++) begin
                bit p;
                p = (k >= wc(j)) && ((k - wc(j)) % (wc(j) + 2) == 0) && ((k - wc(j)) < 9);
                chk($sformatf("held dut%0d ready k=%0d", j, k), {31'b0, rdy[j]}, {31'b0, p});
                chk($sformatf("held dut%0d rdata k=%0d", j, k), rdat[j], p ? xr : 32'h0);
            end
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic r, w;
            logic [31:0] d;
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            case ($urandom_range(0, 3))
                0, 3:    ra = 16'h0010 + 16'(4 * $urandom_range(0, 15));
                1:       ra = 16'(4 * $urandom_range(0, 24));
                default: ra = 16'($urandom_range(0, 96));
            endcase
            model_step(r, w, ra, d, xr, xe);
            txn(r, w, ra, d, xr, xe, $sformatf("rnd%0d", i));
        end

        // Reset during the wait phase of a write: the write is lost, no pulse.
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; ad = 16'h0018; wd = 32'hA5A5_A5A5; v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v = 1'b0; wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) chk($sformatf("midrst dut%0d ready", j), {31'b0, rdy[j]}, 32'h0);
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++)
                chk($sformatf("postrst dut%0d ready k=%0d", j, k), {31'b0, rdy[j]}, 32'h0);
        end
        txn(1'b1, 1'b0, 16'h0018, 32'h0, mem[2], 1'b0, "midrst read");
        txn(1'b1, 1'b0, 16'h0010, 32'h0, 32'h0, 1'b0, "midrst reg0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
